// File: rtl/seven_seg_output_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_output_driver
//
// Purpose:
//   Takes the CPU output register value, converts it to BCD with a
//   sequential shift-add-3 (double-dabble) engine and scans it onto a
//   4-digit multiplexed, active-low seven-segment display. An optional hex
//   view shows the last converted value as two hex digits instead.
//   The block runs on the same divided clock as the core; there is no CDC.
//
// Ports:
//   clk      in   1   block clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   dataIn   in   8   value to display
//   hexMode  in   1   1 = two hex digits, 0 = decimal with leading-zero blanking
//   seg      out  7   segments, active-low, seg[0]=a .. seg[6]=g (registered)
//   dp       out  1   decimal point, active-low, always off
//   an       out  4   digit anodes, active-low, an[0] = rightmost (registered)
//   busy     out  1   high while a conversion is in flight
//   bcdOut   out  12  last completed BCD value {hundreds, tens, ones}
// ---------------------------------------------------------------------------
module seven_seg_output_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  hexMode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [3:0]            an,
    output logic                  busy,
    output logic [11:0]           bcdOut
);

    // Shift register layout: {hundreds, tens, ones, binary}.
    localparam int SHIFT_W = 12 + DATA_WIDTH;
    localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Conversion FSM states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of shift steps for one conversion (one per binary bit).
    localparam logic [3:0] LAST_ITER = 4'(DATA_WIDTH - 1);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [SHIFT_W-1:0] bcd_adjust(input logic [SHIFT_W-1:0] r);
        logic [SHIFT_W-1:0] t;
        t = r;
        for (int k = 0; k < 3; k++) begin
            if (t[DATA_WIDTH + 4*k +: 4] >= 4'd5) begin
                t[DATA_WIDTH + 4*k +: 4] = t[DATA_WIDTH + 4*k +: 4] + 4'd3;
            end else begin
                t[DATA_WIDTH + 4*k +: 4] = t[DATA_WIDTH + 4*k +: 4];
            end
        end
        return t;
    endfunction

    // Hex digit to active-low segment pattern, bit order g..a.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]            state_q,   state_d;
    logic [DATA_WIDTH-1:0] last_q,    last_d;
    logic [DATA_WIDTH-1:0] shown_q,   shown_d;
    logic [SHIFT_W-1:0]    shift_q,   shift_d;
    logic [3:0]            iter_q,    iter_d;
    logic                  busy_q,    busy_d;
    logic [11:0]           bcd_q,     bcd_d;
    logic [CNT_W-1:0]      refresh_q, refresh_d;
    logic [1:0]            digit_q,   digit_d;
    logic [6:0]            seg_q,     seg_d;
    logic [3:0]            an_q,      an_d;

    logic [SHIFT_W-1:0]    adj_s;
    logic [3:0]            nib_s;
    logic                  blank_s;

    assign adj_s = bcd_adjust(shift_q);

    // -----------------------------------------------------------------------
    // Conversion FSM
    // -----------------------------------------------------------------------

    // Next-state logic for change detection and the double-dabble engine.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shown_d = shown_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                // dataIn is only looked at here, so changes during a
                // conversion are picked up by this compare afterwards.
                if (dataIn != last_q) begin
                    last_d  = dataIn;
                    shift_d = {12'b0, dataIn};
                    iter_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_d = {adj_s[SHIFT_W-2:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Result and the value it belongs to are published together
                // so the display never mixes old and new data.
                bcd_d   = shift_q[SHIFT_W-1 -: 12];
                shown_d = last_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Conversion FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            shown_q <= '0;
            shift_q <= '0;
            iter_q  <= 4'd0;
            busy_q  <= 1'b0;
            bcd_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shown_q <= shown_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------

    // Refresh divider; the digit index advances when the divider wraps.
    always_comb begin
        if (refresh_q == CNT_MAX) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
            digit_d   = digit_q;
        end
    end

    // Pick the nibble for the current slot and decide whether it is blank.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b1;
        if (hexMode) begin
            case (digit_q)
                2'd0: begin
                    nib_s   = shown_q[3:0];
                    blank_s = 1'b0;
                end
                2'd1: begin
                    nib_s   = shown_q[7:4];
                    blank_s = 1'b0;
                end
                default: begin
                    nib_s   = 4'd0;
                    blank_s = 1'b1;
                end
            endcase
        end else begin
            case (digit_q)
                2'd0: begin
                    nib_s   = bcd_q[3:0];
                    blank_s = 1'b0;
                end
                2'd1: begin
                    // Leading-zero blanking: tens only shows for values >= 10.
                    nib_s   = bcd_q[7:4];
                    blank_s = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                end
                2'd2: begin
                    nib_s   = bcd_q[11:8];
                    blank_s = (bcd_q[11:8] == 4'd0);
                end
                default: begin
                    nib_s   = 4'd0;
                    blank_s = 1'b1;
                end
            endcase
        end
    end

    // Segment/anode next values; a blank slot turns everything off.
    always_comb begin
        if (blank_s) begin
            seg_d = 7'h7F;
            an_d  = 4'hF;
        end else begin
            seg_d = seg_encode(nib_s);
            an_d  = ~(4'b0001 << digit_q);
        end
    end

    // Scan counter and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
            seg_q     <= 7'h7F;
            an_q      <= 4'hF;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign dp     = 1'b1;
    assign busy   = busy_q;
    assign bcdOut = bcd_q;

endmodule

// File: tb/tb_seven_seg_output_driver.sv
// ---------------------------------------------------------------------------
// Testbench for seven_seg_output_driver (REFRESH_DIV = 4).
// Stimulus pushes the value whose conversion it expects onto a queue; a
// monitor pops on every completed conversion (busy falling) and also checks
// the scanned seg/an pattern every cycle against a model of the display.
// ---------------------------------------------------------------------------
module tb_seven_seg_output_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  dataIn = 8'd0;
    logic        hexMode = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;
    logic [11:0] bcdOut;

    seven_seg_output_driver #(.REFRESH_DIV(DIV), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataIn  (dataIn),
        .hexMode (hexMode),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .busy    (busy),
        .bcdOut  (bcdOut)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int exp_q[$];
    int cnt;          // clock edges since reset release
    int last_drv = 0; // last value driven that triggered a conversion

    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;
            14: return 7'b0000110; 15: return 7'b0001110;
            default: return 7'h7F;
        endcase
    endfunction

    // What slot d should show for value v in the given mode.
    task automatic exp_disp(input int v, input logic hx, input int d,
                            output logic [6:0] es, output logic [3:0] ea);
        bit lit;
        int nib;
        lit = 0;
        nib = 0;
        if (hx) begin
            if (d == 0)      begin lit = 1; nib = v % 16; end
            else if (d == 1) begin lit = 1; nib = v / 16; end
        end else begin
            if (d == 0)                  begin lit = 1; nib = v % 10; end
            else if (d == 1 && v >= 10)  begin lit = 1; nib = (v / 10) % 10; end
            else if (d == 2 && v >= 100) begin lit = 1; nib = v / 100; end
        end
        es = lit ? seg_of(nib) : 7'h7F;
        ea = 4'hF;
        if (lit) ea[d] = 1'b0;
    endtask

    // Monitor: display scan check every cycle, scoreboard pop on busy fall.
    int   cur_v = 0;
    int   lag_v = 0;
    logic lag_h = 1'b0;
    logic prev_busy = 1'b0;
    int   bcyc = 0;
    initial begin
        int v;
        logic [6:0] es;
        logic [3:0] ea;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cur_v = 0; lag_v = 0; prev_busy = 1'b0; bcyc = 0; lag_h = hexMode;
                continue;
            end
            if (cnt >= 1) begin
                exp_disp(lag_v, lag_h, ((cnt - 1) / DIV) % 4, es, ea);
                check("seg", 32'(seg), 32'(es));
                check("an", 32'(an), 32'(ea));
                check("dp", 32'(dp), 32'd1);
            end
            if (busy) bcyc++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_conv: bcdOut=%0h with nothing expected", bcdOut);
                end else begin
                    v = exp_q.pop_front();
                    check("bcdOut", 32'(bcdOut), 32'(to_bcd(v)));
                    check("busy_cycles", 32'(bcyc), 32'd9);
                    cur_v = v;
                end
                bcyc = 0;
            end
            prev_busy = busy;
            lag_v = cur_v;
            lag_h = hexMode;
        end
    end

    task automatic drive(input int v, input logic h);
        @(posedge clk);
        #1;
        dataIn  = 8'(v);
        hexMode = h;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 200);
        if (n >= 200) begin
            nchk++; nerr++;
            $display("FAIL wait_idle: timeout busy=%0b pending=%0d", busy, exp_q.size());
        end
    endtask

    task automatic convert(input int v, input logic h, input int hold);
        exp_q.push_back(v);
        drive(v, h);
        last_drv = v;
        wait_idle();
        repeat (hold) @(posedge clk);
    endtask

    initial begin
        int v;
        int n;
        logic h;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcdOut), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // dataIn stays 0: no conversion, "0" on digit0 only
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_bcd", 32'(bcdOut), 32'd0);

        convert(237, 1'b0, 20);
        convert(5, 1'b0, 20);

        // Change while busy is ignored, then picked up after DONE
        exp_q.push_back(100);
        exp_q.push_back(255);
        drive(100, 1'b0);
        repeat (3) @(posedge clk);
        #1 dataIn = 8'd255;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        check("chain_fall", 32'(busy), 32'd0);
        @(negedge clk);
        check("chain_gap", 32'(busy), 32'd1);
        last_drv = 255;
        wait_idle();
        repeat (16) @(posedge clk);

        // Hex view
        convert(8'hAF, 1'b1, 20);

        // Reset on the 4th SHIFT edge of a 237 conversion
        exp_q.push_back(237);
        drive(237, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_seg", 32'(seg), 32'h7F);
        check("abort_an", 32'(an), 32'hF);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcdOut), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        last_drv = 237;
        wait_idle();
        repeat (16) @(posedge clk);

        // Glitch during SHIFT that returns to the converting value
        exp_q.push_back(42);
        drive(42, 1'b0);
        repeat (2) @(posedge clk);
        #1 dataIn = 8'd199;
        repeat (2) @(posedge clk);
        #1 dataIn = 8'd42;
        last_drv = 42;
        wait_idle();
        repeat (20) @(posedge clk);

        // Random values and modes, with occasional mode flips while idle
        for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(0, 255));
            while (v == last_drv) v = int'($urandom_range(0, 255));
            h = 1'($urandom_range(0, 1));
            convert(v, h, 16 + int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) begin
                drive(v, ~h);
                repeat (17) @(posedge clk);
            end
        end

        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
